// File: rtl/clk_int_div_sync.sv
// -----------------------------------------------------------------------------
// clk_int_div_sync : runtime-programmable integer clock divider with
// glitch-free divisor switching.
//
// Ports
//   clk_i         source clock (only clock of the block)
//   rst_ni        synchronous active-low reset, sampled on rising clk_i
//   en_i          output enable; low parks clk_o low at a period boundary
//   test_mode_i   forces clk_o = clk_i, ungated (DFT bypass)
//   div_i         new divisor (0 and 1 select bypass)
//   div_valid_i   div_i valid
//   div_ready_o   divisor accepted this cycle when high together with valid
//   clk_o         divided or bypassed clock
//   cycl_count_o  current cycle counter value (debug)
//
// Build option
//   ODD_DUTY50_EN  when defined, odd divisors >= 3 get a 50% duty cycle by
//                  OR-ing in a copy of the divided clock delayed by half a
//                  source period (falling-edge flop).
//
// The tc_clk_* modules below are the technology clock cells; everything on
// the clk_o path goes through them.
// -----------------------------------------------------------------------------

module tc_clk_gating (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);
    logic en_latch_s;

    // Enable latch, transparent while clk_i is low
    always_latch begin
        if (!clk_i) begin
            en_latch_s <= en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & en_latch_s;
endmodule

module tc_clk_mux2 (
    input  logic clk0_i,
    input  logic clk1_i,
    input  logic clk_sel_i,
    output logic clk_o
);
    assign clk_o = clk_sel_i ? clk1_i : clk0_i;
endmodule

module tc_clk_inverter (
    input  logic clk_i,
    output logic clk_o
);
    assign clk_o = ~clk_i;
endmodule

module clk_int_div_sync #(
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 test_mode_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic                 div_valid_i,
    output logic                 div_ready_o,
    output logic                 clk_o,
    output logic [DIV_WIDTH-1:0] cycl_count_o
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam logic [DIV_WIDTH-1:0] ZERO_C        = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] ONE_C         = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV_C = DEFAULT_DIV[DIV_WIDTH-1:0];
    localparam logic                 DEFAULT_BYP_C = (DEFAULT_DIV < 2);

    state_e                 state_r, state_nxt_s;
    logic                   hold_cnt_r, hold_cnt_nxt_s;
    logic [DIV_WIDTH-1:0]   div_r, div_pend_r, cnt_r, cnt_nxt_s;
    logic                   pend_valid_r, sel_bypass_r, div_clk_r, ready_r;
    logic                   accept_s, apply_s, div_clk_nxt_s, icg_en_s;
    logic [DIV_WIDTH-1:0]   div_m1_s, half_s;
    logic                   gated_clk_s, div_path_s;

    assign accept_s = div_valid_i & ready_r;
    // Pending divisor lands on the second HOLD edge; both mux inputs are low then.
    assign apply_s  = (state_r == ST_HOLD) && (hold_cnt_r == 1'b0);
    assign div_m1_s = div_r - ONE_C;
    assign half_s   = div_r >> 1;
    // Bypass clock passes only in RUN; DRAIN drops it at once.
    assign icg_en_s = (state_r == ST_RUN) && sel_bypass_r;

    // Next-state, counter and divided-clock computation
    always_comb begin
        state_nxt_s    = state_r;
        hold_cnt_nxt_s = hold_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (accept_s || !en_i) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Divide mode leaves at the last low cycle of the period.
                if (sel_bypass_r || (cnt_r == div_m1_s)) begin
                    state_nxt_s    = ST_HOLD;
                    hold_cnt_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r == 1'b0) begin
                    hold_cnt_nxt_s = 1'b1;
                end else if (en_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s    = ST_HOLD;
                hold_cnt_nxt_s = 1'b0;
            end
        endcase

        if (sel_bypass_r || (state_r == ST_HOLD)) begin
            cnt_nxt_s = ZERO_C;
        end else if (cnt_r == div_m1_s) begin
            cnt_nxt_s = ZERO_C;
        end else begin
            cnt_nxt_s = cnt_r + ONE_C;
        end

        div_clk_nxt_s = (state_nxt_s != ST_HOLD) && !sel_bypass_r && (cnt_nxt_s < half_s);
    end

    // Control and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r      <= ST_HOLD;
            hold_cnt_r   <= 1'b0;
            div_r        <= DEFAULT_DIV_C;
            div_pend_r   <= ZERO_C;
            pend_valid_r <= 1'b0;
            sel_bypass_r <= DEFAULT_BYP_C;
            cnt_r        <= ZERO_C;
            div_clk_r    <= 1'b0;
            ready_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            cnt_r      <= cnt_nxt_s;
            div_clk_r  <= div_clk_nxt_s;
            ready_r    <= (state_nxt_s == ST_RUN);
            if (accept_s) begin
                div_pend_r   <= div_i;
                pend_valid_r <= 1'b1;
            end else if (apply_s && pend_valid_r) begin
                div_r        <= div_pend_r;
                sel_bypass_r <= (div_pend_r < 2'd2);
                pend_valid_r <= 1'b0;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
        end
    end

    tc_clk_gating u_icg (
        .clk_i     (clk_i),
        .en_i      (icg_en_s),
        .test_en_i (test_mode_i),
        .clk_o     (gated_clk_s)
    );

`ifdef ODD_DUTY50_EN
    logic clk_inv_s, div_clk_neg_r, odd_s;

    assign odd_s = div_r[0] & ~sel_bypass_r;

    tc_clk_inverter u_inv (
        .clk_i (clk_i),
        .clk_o (clk_inv_s)
    );

    // Half-period delayed copy of the divided clock, only for odd divisors
    always_ff @(posedge clk_inv_s) begin
        if (!rst_ni) begin
            div_clk_neg_r <= 1'b0;
        end else begin
            div_clk_neg_r <= div_clk_r & odd_s;
        end
    end

    // Clock OR from a mux cell: select the constant-1 leg while div_clk_r is high.
    tc_clk_mux2 u_or (
        .clk0_i    (div_clk_neg_r),
        .clk1_i    (1'b1),
        .clk_sel_i (div_clk_r),
        .clk_o     (div_path_s)
    );
`else
    assign div_path_s = div_clk_r;
`endif

    tc_clk_mux2 u_out_mux (
        .clk0_i    (div_path_s),
        .clk1_i    (gated_clk_s),
        .clk_sel_i (sel_bypass_r | test_mode_i),
        .clk_o     (clk_o)
    );

    assign div_ready_o  = ready_r;
    assign cycl_count_o = cnt_r;
endmodule

// File: tb/tb_clk_int_div_sync.sv
// -----------------------------------------------------------------------------
// tb_clk_int_div_sync : randomized scoreboard bench for clk_int_div_sync.
// The reference model predicts every clk_o pulse (start edge, high time in
// half source periods, counter value at the falling sample) from the
// divisor schedule; a monitor records observed pulses and a comparator pairs
// them up. Handshake-to-ready latency, reset values, DFT bypass and reset
// during a divisor switch are checked directly.
// -----------------------------------------------------------------------------
module tb_clk_int_div_sync;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_ni, en_i, test_mode_i, div_valid_i;
    logic [DW-1:0] div_i;
    logic          div_ready_o, clk_o;
    logic [DW-1:0] cycl_count_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int start;
        int halves;
        int cnt_fall;
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t obs_q[$];
    pulse_t cmp_e, cmp_o;

    // reference model state: current segment of identical pulses
    int seg_start, seg_n;

    // monitor state
    bit mon_prev = 1'b0;
    int mon_len = 0;
    int mon_start = 0;

    int dir_ops [10] = '{4, 6, 5, 8, -1, 1, 3, 0, 2, 7};

    clk_int_div_sync #(.DIV_WIDTH(DW), .DEFAULT_DIV(1)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .test_mode_i  (test_mode_i),
        .div_i        (div_i),
        .div_valid_i  (div_valid_i),
        .div_ready_o  (div_ready_o),
        .clk_o        (clk_o),
        .cycl_count_o (cycl_count_o)
    );

    // Source clock, period 10
    always #5 clk = ~clk;

    // Rising-edge index: after posedge k, cyc == k
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    // High time of one pulse in half source periods
    function automatic int high_halves(input int n);
        if (n < 2) return 1;
`ifdef ODD_DUTY50_EN
        if ((n % 2) == 1) return 2 * (n / 2) + 1;
`endif
        return 2 * (n / 2);
    endfunction

    // Close the running segment at accept edge a: queue all of its pulses and
    // return the edge at which the output goes into its 2-cycle hold.
    function automatic int close_segment(input int a);
        int last;
        if (seg_n < 2) begin
            for (int t = seg_start; t <= a; t++) exp_q.push_back('{t, 1, 0});
            return a + 1;
        end
        last = seg_start + ((a - seg_start) / seg_n) * seg_n;
        for (int t = seg_start; t <= last; t += seg_n)
            exp_q.push_back('{t, high_halves(seg_n), seg_n / 2});
        return last + seg_n;
    endfunction

    task automatic mon_sample(input bit at_pos);
        if (!mon_en) begin
            mon_prev = 1'b0;
            mon_len  = 0;
        end else begin
            if (clk_o) begin
                if (!mon_prev) begin
                    mon_start = at_pos ? cyc : -1;
                    mon_len   = 0;
                end
                mon_len++;
            end else if (mon_prev) begin
                obs_q.push_back('{mon_start, mon_len, int'(cycl_count_o)});
            end
            mon_prev = clk_o;
        end
    endtask

    // Monitor: sample clk_o once per half period, away from the edges
    initial begin
        forever begin
            @(posedge clk); #1; mon_sample(1'b1);
            @(negedge clk); #1; mon_sample(1'b0);
        end
    end

    // Comparator: pair expected and observed pulses in order
    always @(negedge clk) begin
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            cmp_o = obs_q.pop_front();
            check("pulse_start_edge", cmp_o.start, cmp_e.start);
            check("pulse_high_halves", cmp_o.halves, cmp_e.halves);
            check("count_at_fall", cmp_o.cnt_fall, cmp_e.cnt_fall);
        end
    end

    // Wait (bounded) at negedges for ready; exp_edge < 0 skips the latency check
    task automatic wait_ready(input int exp_edge, input string name);
        int n;
        n = 0;
        while (div_ready_o !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check({name, "_timeout"}, 0, 1);
        else if (exp_edge >= 0) check(name, cyc, exp_edge);
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus and directed checks
    initial begin
        int run_e, end_e, a, c1, c2;
        rst_ni = 1'b0; en_i = 1'b1; test_mode_i = 1'b0;
        div_valid_i = 1'b0; div_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", int'(div_ready_o), 0);
        check("reset_clk_o", int'(clk_o), 0);
        check("reset_count", int'(cycl_count_o), 0);

        @(negedge clk);
        rst_ni = 1'b1;
        mon_en = 1'b1;
        run_e  = cyc + 2;
        seg_n  = 1;
        seg_start = run_e + 1;
        wait_ready(run_e, "ready_after_reset");

        for (int i = 0; i < 28; i++) begin
            int n_new, op;
            bit wr, park;
            repeat ($urandom_range(0, 12)) @(negedge clk);
            if (i < 10) op = dir_ops[i];
            else begin
                op = $urandom_range(0, 9);
                if (op == 0) op = -1;
                else if (op == 1) op = $urandom_range(0, 1);
                else if (op == 2) op = 100;
                else op = $urandom_range(2, 9);
            end
            park  = (op == -1) || (op == 100);
            wr    = (op != -1);
            n_new = (op == 100) ? $urandom_range(0, 9) : op;

            if (wr) begin
                div_i = n_new[DW-1:0];
                div_valid_i = 1'b1;
            end
            if (park) en_i = 1'b0;
            a = cyc + 1;
            end_e = close_segment(a);
            @(negedge clk);
            // held valid while not ready must be ignored
            div_valid_i = ($urandom_range(0, 1) == 1);
            div_i = $urandom_range(0, 255);
            @(negedge clk);
            div_valid_i = 1'b0;
            if (park) begin
                repeat ($urandom_range(0, 12)) @(negedge clk);
                en_i = 1'b1;
                run_e = (end_e + 2 > cyc + 1) ? end_e + 2 : cyc + 1;
            end else begin
                run_e = end_e + 2;
            end
            wait_ready(run_e, "ready_return_edge");
            if (wr) seg_n = n_new;
            seg_start = run_e + ((seg_n < 2) ? 1 : 0);
        end

        // Park for good and flush the scoreboard
        repeat (3) @(negedge clk);
        en_i = 1'b0;
        end_e = close_segment(cyc + 1);
        repeat (30) @(negedge clk);
        check("expected_left", exp_q.size(), 0);
        check("observed_left", obs_q.size(), 0);
        @(posedge clk); #1;
        check("parked_clk_o", int'(clk_o), 0);
        mon_en = 1'b0;

        // DFT bypass while dividing by 3
        @(negedge clk);
        en_i = 1'b1;
        wait_ready(-1, "ready_unpark");
        div_i = 8'd3; div_valid_i = 1'b1;
        @(negedge clk);
        div_valid_i = 1'b0;
        wait_ready(-1, "ready_div3");
        repeat (7) @(negedge clk);
        test_mode_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("test_mode_clk_high", int'(clk_o), 1);
            c1 = cycl_count_o;
            @(negedge clk); #1;
            check("test_mode_clk_low", int'(clk_o), 0);
            @(posedge clk); #1;
            c2 = cycl_count_o;
            check("test_mode_count_runs", c2, (c1 + 1) % 3);
        end
        @(negedge clk);
        test_mode_i = 1'b0;

        // Reset in the middle of a divisor switch discards the pending value
        repeat (4) @(negedge clk);
        div_i = 8'd7; div_valid_i = 1'b1;
        @(negedge clk);
        div_valid_i = 1'b0;
        check("drain_ready_low", int'(div_ready_o), 0);
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mid_ready", int'(div_ready_o), 0);
        check("rst_mid_count", int'(cycl_count_o), 0);
        check("rst_mid_clk_o", int'(clk_o), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_ready", int'(div_ready_o), 1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("post_rst_bypass_clk", int'(clk_o), 1);
            check("post_rst_count", int'(cycl_count_o), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_int_div_sync.md
Name: clk_int_div_sync

Overview:
Runtime-programmable integer clock divider. It is the generating end of the clock network: it produces the divided clocks that downstream clock muxes, buffers and inverters distribute and select between. It takes a single source clock, divides it by a divisor written through a valid/ready handshake, and switches divisors glitch-free. All output-path gating, muxing and inversion is built from the existing technology clock cells; no behavioural logic sits on the clock path.

Parameters:
DIV_WIDTH, 8, width of divisor input and internal cycle counter
DEFAULT_DIV, 1, divisor loaded at reset (0 and 1 both mean bypass)

Ports:
clk_i  input  1  source clock; the only clock of the block
rst_ni  input  1  synchronous, active-low reset, sampled on rising clk_i
en_i  input  1  output enable; 0 parks clk_o low at a period boundary
test_mode_i  input  1  1 forces clk_o = clk_i, ungated (DFT bypass)
div_i  input  DIV_WIDTH  new divisor value
div_valid_i  input  1  div_i valid
div_ready_o  output  1  block accepts div_i this cycle
clk_o  output  1  divided or bypassed clock
cycl_count_o  output  DIV_WIDTH  current counter value (debug)

Behaviour:
- Reset: synchronous active-low; one clock; all flops on rising clk_i unless stated.
- Reset values (rst_ni low at an edge): div_q=DEFAULT_DIV, cnt=0, state=HOLD with hold_cnt=0, div_ready_o=0, clk_o=0, cycl_count_o=0.
- Divisor N = div_q. N in {0,1} → bypass mode: clk_o = clk_i through an ICG. The ICG enable is latched while clk_i is low and is high only in RUN.
- N≥2 → divide mode: cnt runs 0..N-1 and wraps to 0.
  - Registered divided clock div_clk_q = (cnt < N/2) using floor division.
  - Even N gives 50% duty. Odd N without the optional feature gives floor(N/2)/N high time.
- clk_o = clock-mux(sel_bypass_q ? gated clk_i : div_clk_q). sel_bypass_q changes only in HOLD, while both mux inputs are low.
- FSM states:
  - RUN: div_ready_o=1 when no request is pending. Accept on div_valid_i & div_ready_o: capture div_i into div_pend_q and go to DRAIN. en_i falling also goes to DRAIN, with no pending divisor.
  - DRAIN: div_ready_o=0. Divide mode: wait for cnt==N-1, which is the end of the low phase. Bypass mode: drop the ICG enable immediately. Then go to HOLD.
  - HOLD: clk_o forced low for exactly 2 clk_i cycles. cnt=0. Apply div_pend_q to div_q and update sel_bypass_q. Exit to RUN only if en_i=1; otherwise stay in HOLD with clk_o low.
- Latency, handshake to first new rising edge on clk_o, is worst case (N_old-1) + 2 + 1 cycles. In bypass, handshake to first new edge is 3 cycles.
- div_valid_i held high while not ready: no effect, value not captured. div_i must be stable while valid and not ready; not checked.
- Simultaneous divisor request and en_i fall: divisor captured, output parks after HOLD.
- Writing the same divisor: full DRAIN/HOLD sequence still runs; no shortcut.
- Reset mid-DRAIN/HOLD: pending divisor discarded; div_q=DEFAULT_DIV.
- test_mode_i=1 overrides the mux select and ICG enable combinationally. FSM and counter keep running.
- cycl_count_o = cnt. It is 0 in bypass and HOLD.
- No high pulse on clk_o may be shorter than one clk_i high phase, under any sequence of events.

Optional Feature:
ODD_DUTY50_EN: when defined, odd N≥3 gets a 50% duty cycle.
- A second flop, clocked on falling clk_i (via clock inverter cell), samples div_clk_q.
- clk_o in divide mode = div_clk_q OR neg-delayed copy (clock OR built from xor/mux cells). The OR is applied only when N is odd.
- When undefined: no falling-edge flops; odd-N duty is floor(N/2)/N. Even-N and bypass behaviour are identical in both builds.

Test Plan:
- Reset with DEFAULT_DIV=1, en_i=1 → clk_o low 2 cycles after reset release, then clk_o = clk_i, div_ready_o=1.
- Write div_i=4 from bypass → clk_o low exactly 2 cycles, then period 4 with high 2 / low 2, cycl_count_o cycles 0..3, no runt pulse.
- Divide 4 → write 6 mid high phase → current period completes, 2-cycle low hold, then period 6 with high 3; div_ready_o low throughout the switch.
- Write div_i=5 → period 5. Feature off: high 2 cycles. Feature on: high 2.5 cycles (measured edge to edge).
- en_i=0 during divide-by-8 → clk_o parks low after the current period ends. en_i=1 → first rising edge 1 cycle after leaving HOLD.
- test_mode_i=1 during divide-by-3 → clk_o = clk_i immediately. Assert rst_ni low mid-DRAIN → div_q=DEFAULT_DIV and the pending value is lost.
